// File: rtl/spi_rx_fifo_pkg.sv
// rtl/spi_rx_fifo_pkg.sv - default parameters shared by the SPI/SD receive path
package spi_rx_fifo_pkg;
  localparam int DEF_DATA_W    = 8;
  localparam int DEF_DEPTH     = 8;
  localparam int DEF_SYNC_STG  = 2;
  localparam int DEF_AFULL_LVL = 6;
endpackage

// File: rtl/spi_rx_fifo_if.sv
// rtl/spi_rx_fifo_if.sv - receive strobe/data and bus-side read/status bundle
interface spi_rx_fifo_if #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 8
);
  localparam int LVL_W = $clog2(DEPTH + 1);

  logic              rx_valid;
  logic [DATA_W-1:0] rx_data;
  logic              rd_req;
  logic              rd_valid;
  logic [DATA_W-1:0] rd_data;
  logic [LVL_W-1:0]  level;
  logic              empty;
  logic              full;
  logic              almost_full;
  logic              overflow;
  logic              underflow;

  modport master (
    output rx_valid, rx_data, rd_req,
    input  rd_valid, rd_data, level, empty, full, almost_full, overflow, underflow
  );

  modport slave (
    input  rx_valid, rx_data, rd_req,
    output rd_valid, rd_data, level, empty, full, almost_full, overflow, underflow
  );
endinterface

// File: rtl/sync_rise_detect.sv
// rtl/sync_rise_detect.sv - async-input synchroniser with one-cycle rise pulse
module sync_rise_detect #(
  parameter int SYNC_STG = 2
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic async_i,
  output logic rise_o
);
  logic [SYNC_STG-1:0] sync_q, sync_d;
  logic                hist_q;

  always_comb begin
    sync_d = {sync_q[SYNC_STG-2:0], async_i};
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sync_q <= '0;
      hist_q <= 1'b0;
    end else begin
      sync_q <= sync_d;
      hist_q <= sync_q[SYNC_STG-1];
    end
  end

  assign rise_o = sync_q[SYNC_STG-1] & ~hist_q;
endmodule

// File: rtl/spi_rx_fifo.sv
// rtl/spi_rx_fifo.sv - receive FIFO fed by a level-held strobe, popped by rd_req
module spi_rx_fifo
  import spi_rx_fifo_pkg::*;
#(
  parameter int DATA_W    = DEF_DATA_W,
  parameter int DEPTH     = DEF_DEPTH,
  parameter int SYNC_STG  = DEF_SYNC_STG,
  parameter int AFULL_LVL = DEF_AFULL_LVL
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         clear_i,
  spi_rx_fifo_if.slave bus
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int LVL_W = $clog2(DEPTH + 1);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0]  level_q, level_d;
  logic              empty_q, empty_d, full_q, full_d, afull_q, afull_d;
  logic              ovf_q, ovf_d, udf_q, udf_d;
  logic              rd_valid_q, rd_valid_d;
  logic [DATA_W-1:0] rd_data_q, rd_data_d;
  logic              push, do_push, do_pop;

  sync_rise_detect #(.SYNC_STG(SYNC_STG)) u_sync (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .async_i(bus.rx_valid),
    .rise_o (push)
  );

  // A pop in the same cycle frees the slot, so a push into a full FIFO survives.
  assign do_pop  = bus.rd_req && !empty_q;
  assign do_push = push && (!full_q || do_pop);

  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    level_d    = level_q;
    ovf_d      = ovf_q;
    udf_d      = udf_q;
    rd_valid_d = 1'b0;
    rd_data_d  = rd_data_q;
    if (clear_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      level_d  = '0;
      ovf_d    = 1'b0;
      udf_d    = 1'b0;
    end else begin
      wr_ptr_d   = wr_ptr_q + PTR_W'(do_push);
      rd_ptr_d   = rd_ptr_q + PTR_W'(do_pop);
      level_d    = level_q + LVL_W'(do_push) - LVL_W'(do_pop);
      rd_valid_d = do_pop;
      if (do_pop) rd_data_d = mem_q[rd_ptr_q];
      if (push && !do_push) ovf_d = 1'b1;
      if (bus.rd_req && empty_q) udf_d = 1'b1;
    end
    empty_d = (level_d == '0);
    full_d  = (level_d == LVL_W'(DEPTH));
    afull_d = (level_d >= LVL_W'(AFULL_LVL));
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      level_q    <= '0;
      empty_q    <= 1'b1;
      full_q     <= 1'b0;
      afull_q    <= 1'b0;
      ovf_q      <= 1'b0;
      udf_q      <= 1'b0;
      rd_valid_q <= 1'b0;
      rd_data_q  <= '0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      level_q    <= level_d;
      empty_q    <= empty_d;
      full_q     <= full_d;
      afull_q    <= afull_d;
      ovf_q      <= ovf_d;
      udf_q      <= udf_d;
      rd_valid_q <= rd_valid_d;
      rd_data_q  <= rd_data_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push && !clear_i) mem_q[wr_ptr_q] <= bus.rx_data;
  end

  assign bus.rd_valid    = rd_valid_q;
  assign bus.rd_data     = rd_data_q;
  assign bus.level       = level_q;
  assign bus.empty       = empty_q;
  assign bus.full        = full_q;
  assign bus.almost_full = afull_q;
  assign bus.overflow    = ovf_q;
  assign bus.underflow   = udf_q;
endmodule
